// File: rtl/mysystem_onchip_mem_arbiter.sv
// Round-robin arbiter that shares the single-port on-chip memory between the
// instruction-fetch master (M0, read-only) and the data master (M1, read/write/lock).
module mysystem_onchip_mem_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BE_W     = DATA_W / 8,
    parameter int unsigned MAX_LOCK = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_debugaccess,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_e;

    mst_e              rr_last;
    logic              lock_active;
    logic [CNT_W-1:0]  lock_cnt;
    logic              rdv0;
    logic              rdv1;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;

    logic req0;
    logic req1;
    logic grant0;
    logic grant1;

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

    // Grant from registered arbitration state; nothing is granted while in reset or frozen.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && !freeze) begin
            if (lock_active) begin
                grant1 = req1;
            end else if (req0 && req1) begin
                grant0 = (rr_last == MST_M1);
                grant1 = (rr_last == MST_M0);
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    // Memory command mux; when idle the address/data/byteenable hold their last value.
    always_comb begin
        mem_address    = addr_q;
        mem_byteenable = be_q;
        mem_writedata  = wdata_q;
        if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = {BE_W{1'b1}};
        end else if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_chipselect   = grant0 | grant1;
    assign mem_write        = grant1 & m1_write;
    assign mem_debugaccess  = grant1 & m1_debugaccess;
    assign mem_clken        = ~freeze;

    assign m0_waitrequest   = ~grant0;
    assign m1_waitrequest   = ~grant1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rdv0;
    assign m1_readdatavalid = rdv1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= mem_address;
            be_q    <= mem_byteenable;
            wdata_q <= mem_writedata;
        end
    end

    // Round-robin pointer, read-valid pipeline and M1 lock tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last     <= MST_M1;
            lock_active <= 1'b0;
            lock_cnt    <= '0;
            rdv0        <= 1'b0;
            rdv1        <= 1'b0;
        end else begin
            rdv0 <= grant0;
            rdv1 <= grant1 & m1_read & ~m1_write;
            if (grant0) begin
                rr_last <= MST_M0;
            end else if (grant1) begin
                rr_last <= MST_M1;
            end
            // lock_cnt counts locked cycles including the command that took the lock
            if (lock_active) begin
                if (lock_cnt == CNT_W'(MAX_LOCK)) begin
                    lock_active <= 1'b0;
                    lock_cnt    <= '0;
                    rr_last     <= MST_M1;
                end else if (!m1_lock && (grant1 || !req1)) begin
                    lock_active <= 1'b0;
                    lock_cnt    <= '0;
                end else begin
                    lock_cnt <= lock_cnt + CNT_W'(1);
                end
            end else if (grant1 && m1_lock) begin
                lock_active <= 1'b1;
                lock_cnt    <= CNT_W'(1);
            end
        end
    end

endmodule
